// File: rtl/srr_shift_sched.sv
// srr_shift_sched: round-robin scheduler feeding one serial-in shift register and returning its loopback word
module srr_shift_sched #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_data1,
  output logic [1:0]       req_ready,
  output logic             sr_en,
  output logic             sr_d,
  input  logic [WIDTH-1:0] sr_q,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE, RESP} state_t;
  state_t state;
  logic ptr, id_q, g, take;
  logic [CW-1:0] cnt, idx;
  logic [WIDTH-1:0] data_q;
  // req_ready is gated by rst_n so it reads 0 while reset is held in IDLE
  always_comb begin
    g = &req_valid ? ptr : req_valid[1];
    take = rst_n && state == IDLE && |req_valid;
    req_ready = take ? (g ? 2'b10 : 2'b01) : 2'b00;
    idx = CW'(WIDTH - 1) - cnt;
    sr_en = state == SHIFT;
    sr_d = sr_en & data_q[idx];
    rsp_valid = state == RESP;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= 1'b0;
      cnt <= '0;
      data_q <= '0;
      id_q <= 1'b0;
      rsp_data <= '0;
      rsp_err <= 1'b0;
      rsp_id <= 1'b0;
    end else begin
      case (state)
        IDLE: if (take) begin
          data_q <= g ? req_data1 : req_data0;
          id_q <= g;
          ptr <= ~g;
          cnt <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= CAPTURE;
        end
        CAPTURE: begin
          rsp_data <= sr_q;
          rsp_err <= sr_q != data_q;
          rsp_id <= id_q;
          state <= RESP;
        end
        RESP: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
